div_bcd_fmt: RTL and testbench

DIV_BCD_FMT -- requirements
Module: div_bcd_fmt

---
 rtl/div_pkg.sv | 16 +
 rtl/bcd_add3.sv | 11 +
 rtl/div_bcd_fmt.sv | 105 ++++++++++
 tb/tb_div_bcd_fmt.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types for the divider datapath: FSM state encoding and BCD digit.
package div_pkg;

    typedef logic [3:0] bcd_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Double-dabble correction: digits at or above 5 get 3 added before the shift
    localparam bcd_t BCD_ADJ_MIN = 4'd5;
    localparam bcd_t BCD_ADJ     = 4'd3;

endpackage

// File: rtl/bcd_add3.sv
// Combinational double-dabble digit correction (add 3 when the digit is >= 5).
module bcd_add3
    import div_pkg::*;
(
    input  bcd_t d,
    output bcd_t y
);

    assign y = (d >= BCD_ADJ_MIN) ? bcd_t'(d + BCD_ADJ) : d;

endmodule

// File: rtl/div_bcd_fmt.sv
// Converts a divider result (quotient, remainder) to two-digit BCD each,
// one double-dabble step per clock, with valid/ready handshakes on both sides.
module div_bcd_fmt
    import div_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] q,
    input  logic [W-1:0] r,
    output logic [3:0]   q_tens,
    output logic [3:0]   q_ones,
    output logic [3:0]   r_tens,
    output logic [3:0]   r_ones,
    output logic         out_valid,
    input  logic         out_ready
);

    localparam int             CW       = $clog2(W + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(W - 1);

    state_e        state;
    logic [CW-1:0] cnt;
    logic [W-1:0]  q_sr;
    logic [W-1:0]  r_sr;
    logic [7:0]    q_acc;
    logic [7:0]    r_acc;
    bcd_t          q_adj_t;
    bcd_t          q_adj_o;
    bcd_t          r_adj_t;
    bcd_t          r_adj_o;
    logic [7:0]    q_step;
    logic [7:0]    r_step;

    bcd_add3 u_add3_qt (.d(q_acc[7:4]), .y(q_adj_t));
    bcd_add3 u_add3_qo (.d(q_acc[3:0]), .y(q_adj_o));
    bcd_add3 u_add3_rt (.d(r_acc[7:4]), .y(r_adj_t));
    bcd_add3 u_add3_ro (.d(r_acc[3:0]), .y(r_adj_o));

    // Corrected digits shifted left, pulling in the next MSB of the captured value.
    // The tens digit never reaches 8 before the last shift for W <= 6, so its
    // top bit can be dropped.
    assign q_step = ({q_adj_t, q_adj_o} << 1) | {7'd0, q_sr[W-1]};
    assign r_step = ({r_adj_t, r_adj_o} << 1) | {7'd0, r_sr[W-1]};

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);

    // Handshake FSM, conversion datapath and registered digit outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            q_sr   <= '0;
            r_sr   <= '0;
            q_acc  <= '0;
            r_acc  <= '0;
            q_tens <= '0;
            q_ones <= '0;
            r_tens <= '0;
            r_ones <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        q_sr  <= q;
                        r_sr  <= r;
                        q_acc <= '0;
                        r_acc <= '0;
                        cnt   <= '0;
                        state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    q_acc <= q_step;
                    r_acc <= r_step;
                    q_sr  <= q_sr << 1;
                    r_sr  <= r_sr << 1;
                    cnt   <= cnt + CW'(1);
                    // Digits are published only on the final step, so a
                    // partial result is never visible on the outputs
                    if (cnt == CNT_LAST) begin
                        q_tens <= q_step[7:4];
                        q_ones <= q_step[3:0];
                        r_tens <= r_step[7:4];
                        r_ones <= r_step[3:0];
                        state  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_bcd_fmt.sv
// Self-checking bench for div_bcd_fmt: directed cases, backpressure, ignored
// inputs while busy, mid-conversion reset, exhaustive sweep and random traffic.
module tb_div_bcd_fmt;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic [3:0]   q_tens;
    logic [3:0]   q_ones;
    logic [3:0]   r_tens;
    logic [3:0]   r_ones;
    logic         out_valid;
    logic         out_ready;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    div_bcd_fmt #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .q         (q),
        .r         (r),
        .q_tens    (q_tens),
        .q_ones    (q_ones),
        .r_tens    (r_tens),
        .r_ones    (r_ones),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    // Reference: decimal digits of (qv, rv) packed as {q_tens, q_ones, r_tens, r_ones}
    function automatic logic [15:0] ref_digits(input int qv, input int rv);
        logic [3:0] qt, qo, rt, ro;
        qt = 4'(qv / 10);
        qo = 4'(qv % 10);
        rt = 4'(rv / 10);
        ro = 4'(rv % 10);
        return {qt, qo, rt, ro};
    endfunction

    function automatic logic [15:0] got_digits();
        return {q_tens, q_ones, r_tens, r_ones};
    endfunction

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Present (qv, rv), wait for acceptance, then count edges until out_valid
    task automatic run_one(input int qv, input int rv, output int lat);
        int guard;
        q = W'(qv);
        r = W'(rv);
        in_valid = 1'b1;
        guard = 0;
        while (!in_ready && guard < 20) begin
            tick();
            guard++;
        end
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        q = '0;
        r = '0;
        tick();
        tick();
        rst = 1'b1;
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_out_valid: got %b expected 0", out_valid);
        end
        tests++;
        if (got_digits() !== 16'h0000) begin
            fails++;
            $display("FAIL reset_digits: got %h expected 0000", got_digits());
        end
    endtask

    task automatic test_directed();
        int qs[3] = '{15, 7, 10};
        int rs[3] = '{0, 1, 9};
        int lat;
        for (int i = 0; i < 3; i++) begin
            run_one(qs[i], rs[i], lat);
            tests++;
            if (lat !== W) begin
                fails++;
                $display("FAIL directed_latency q=%0d r=%0d: got %0d expected %0d", qs[i], rs[i], lat, W);
            end
            tests++;
            if (got_digits() !== ref_digits(qs[i], rs[i])) begin
                fails++;
                $display("FAIL directed_digits q=%0d r=%0d: got %h expected %h",
                         qs[i], rs[i], got_digits(), ref_digits(qs[i], rs[i]));
            end
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            tests++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                fails++;
                $display("FAIL directed_release: got out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
            end
        end
    endtask

    task automatic test_backpressure();
        int lat;
        logic [15:0] exp_d;
        exp_d = ref_digits(12, 5);
        run_one(12, 5, lat);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tests++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || got_digits() !== exp_d) begin
                fails++;
                $display("FAIL backpressure_hold cycle %0d: got valid=%b ready=%b digits=%h expected 1/0/%h",
                         i, out_valid, in_ready, got_digits(), exp_d);
            end
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL backpressure_release: got valid=%b ready=%b expected 0/1", out_valid, in_ready);
        end
        tests++;
        if (got_digits() !== exp_d) begin
            fails++;
            $display("FAIL backpressure_keep_digits: got %h expected %h", got_digits(), exp_d);
        end
    endtask

    task automatic test_ignore_busy();
        int guard;
        q = 4'd12;
        r = 4'd4;
        in_valid = 1'b1;
        tick();
        // Pulse a different operand while the conversion is running
        q = 4'd3;
        r = 4'd11;
        tick();
        tick();
        in_valid = 1'b0;
        guard = 0;
        while (!out_valid && guard < 20) begin
            tick();
            guard++;
        end
        tests++;
        if (got_digits() !== ref_digits(12, 4)) begin
            fails++;
            $display("FAIL ignore_busy_digits: got %h expected %h", got_digits(), ref_digits(12, 4));
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < W + 2; i++) tick();
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL ignore_busy_no_capture: got valid=%b ready=%b expected 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_mid_reset();
        int lat;
        q = 4'd9;
        r = 4'd8;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || got_digits() !== 16'h0000) begin
            fails++;
            $display("FAIL mid_shift_reset: got ready=%b valid=%b digits=%h expected 1/0/0000",
                     in_ready, out_valid, got_digits());
        end
        for (int i = 0; i < W + 1; i++) begin
            tick();
            tests++;
            if (out_valid !== 1'b0) begin
                fails++;
                $display("FAIL mid_shift_no_partial cycle %0d: got %b expected 0", i, out_valid);
            end
        end
        run_one(13, 6, lat);
        tests++;
        if (lat !== W || got_digits() !== ref_digits(13, 6)) begin
            fails++;
            $display("FAIL after_reset_convert: got lat=%0d digits=%h expected %0d/%h",
                     lat, got_digits(), W, ref_digits(13, 6));
        end
        // Reset while DONE is being held by backpressure
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || got_digits() !== 16'h0000) begin
            fails++;
            $display("FAIL done_reset: got ready=%b valid=%b digits=%h expected 1/0/0000",
                     in_ready, out_valid, got_digits());
        end
    endtask

    task automatic test_sweep();
        int guard;
        int acc_cyc;
        int prev_cyc;
        prev_cyc = -1;
        out_ready = 1'b1;
        in_valid = 1'b1;
        for (int qv = 0; qv < 16; qv++) begin
            for (int rv = 0; rv < 16; rv++) begin
                q = 4'(qv);
                r = 4'(rv);
                guard = 0;
                while (!in_ready && guard < 20) begin
                    tick();
                    guard++;
                end
                acc_cyc = cyc;
                if (prev_cyc >= 0) begin
                    tests++;
                    if (acc_cyc - prev_cyc !== W + 2) begin
                        fails++;
                        $display("FAIL sweep_period q=%0d r=%0d: got %0d expected %0d",
                                 qv, rv, acc_cyc - prev_cyc, W + 2);
                    end
                end
                prev_cyc = acc_cyc;
                tick();
                guard = 0;
                while (!out_valid && guard < 20) begin
                    tick();
                    guard++;
                end
                tests++;
                if (got_digits() !== ref_digits(qv, rv)) begin
                    fails++;
                    $display("FAIL sweep_digits q=%0d r=%0d: got %h expected %h",
                             qv, rv, got_digits(), ref_digits(qv, rv));
                end
            end
        end
        in_valid = 1'b0;
        tick();
        out_ready = 1'b0;
        tick();
    endtask

    task automatic test_random();
        int qv, rv, lat, hold;
        for (int n = 0; n < 24; n++) begin
            qv = int'($urandom_range(0, 15));
            rv = int'($urandom_range(0, 15));
            q = 4'(qv);
            r = 4'(rv);
            in_valid = 1'b1;
            tick();
            lat = 0;
            while (!out_valid && lat < 20) begin
                in_valid = 1'($urandom_range(0, 1));
                q = 4'($urandom_range(0, 15));
                r = 4'($urandom_range(0, 15));
                tick();
                lat++;
            end
            in_valid = 1'b0;
            tests++;
            if (lat !== W || got_digits() !== ref_digits(qv, rv)) begin
                fails++;
                $display("FAIL random q=%0d r=%0d: got lat=%0d digits=%h expected %0d/%h",
                         qv, rv, lat, got_digits(), W, ref_digits(qv, rv));
            end
            hold = int'($urandom_range(0, 3));
            for (int i = 0; i < hold; i++) tick();
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            tests++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                fails++;
                $display("FAIL random_release: got valid=%b ready=%b expected 0/1", out_valid, in_ready);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_ignore_busy();
        test_mid_reset();
        test_sweep();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Absolute time bound so a stuck handshake can never hang the run
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
